regfile_master: RTL
===================

REGFILE_MASTER -- requirements
Module: regfile_master

Interface
REQ-001 Parameter DATA_W, default 4, register data width in bits.
REQ-002 Parameter ADDR_W, default 5, register address width; register file depth is 2**ADDR_W.
REQ-003 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, reset; synchronous and active-high.
REQ-005 Port cmd_valid, input, 1, command offered.
REQ-006 Port cmd_ready, output, 1, command accepted when cmd_valid and cmd_ready are both high in the same cycle.
REQ-007 Port cmd_we, input, 1, 1 = write command, 0 = read command.
REQ-008 Port cmd_addr1, input, ADDR_W, write address or first read address.
REQ-009 Port cmd_addr2, input, ADDR_W, second read address; ignored for writes.
REQ-010 Port cmd_wdata, input, DATA_W, write data.
REQ-011 Port rsp_valid / rsp_ready, output / input, 1 each, read-response handshake.
REQ-012 Port rsp_data1 / rsp_data2, output, DATA_W each, read results.
REQ-013 Ports rf_rd_addr1, rf_rd_addr2, rf_wr_addr, output, ADDR_W each, register-file addresses.
REQ-014 Ports rf_wr_data, output, DATA_W; rf_wen, output, 1; rf_stall, output, 1; rf_rd_data1 / rf_rd_data2, input, DATA_W each.

Function
REQ-015 The attached register file SHALL be treated as write-first: it registers the read addresses when rf_stall=0, and data appears on rf_rd_data* in the following cycle.
REQ-016 The FSM SHALL have four states: CLEAR, IDLE, RD_WAIT and RESP.
REQ-017 IDLE: cmd_ready=1, rf_stall=0, and rf_rd_addr1/2 SHALL pass cmd_addr1/2 through combinationally.
REQ-018 A write accepted in cycle t SHALL drive rf_wen=1, rf_wr_addr=cmd_addr1 and rf_wr_data=cmd_wdata, all registered, for exactly cycle t+1.
REQ-019 The FSM SHALL stay in IDLE after a write, so back-to-back writes sustain one per cycle.
REQ-020 A read accepted in cycle t SHALL move the FSM to RD_WAIT for cycle t+1; cmd_ready=0 and rf_stall=1 there.
REQ-021 At the end of RD_WAIT, rf_rd_data1/2 SHALL be captured into rsp_data1/2, and the FSM SHALL enter RESP with rsp_valid=1 from cycle t+2.
REQ-022 RESP: rsp_valid, rsp_data1 and rsp_data2 SHALL be held stable, with cmd_ready=0 and rf_stall=1, until rsp_ready=1; the FSM then returns to IDLE in the next cycle.
REQ-023 A read accepted the cycle after a write to the same address SHALL return the newly written data.
REQ-024 rf_wen SHALL be 0 in every cycle not covered by REQ-018 or REQ-029.
REQ-025 rsp_data1/2 SHALL be unchanged outside the capture cycle.

Reset
REQ-026 On rst=1 at a clock edge: cmd_ready=0, rsp_valid=0, rsp_data1/2=0, rf_wen=0, rf_stall=0, rf_wr_addr=0, rf_wr_data=0, and any pending write pulse or in-flight read SHALL be discarded.
REQ-027 The state after reset SHALL be CLEAR when RF_CLEAR_EN is defined, and IDLE otherwise; rst asserted mid-sweep SHALL restart the sweep at address 0.

Configuration
REQ-028 Macro RF_CLEAR_EN SHALL compile the post-reset clear sweep in or out.
REQ-029 With RF_CLEAR_EN defined, CLEAR SHALL run for 2**ADDR_W cycles.
  - rf_wen=1, rf_wr_data=0, rf_wr_addr counting 0 to 2**ADDR_W-1.
  - cmd_ready=0 throughout.
  - The FSM then enters IDLE, with first cmd_ready=1 in cycle 2**ADDR_W after reset release (cycle 32 at defaults).
REQ-030 Without RF_CLEAR_EN, the CLEAR state and its counter SHALL be absent, and cmd_ready=1 in the first cycle after reset release.

Verification
REQ-031 Reset release with RF_CLEAR_EN -> 32 cycles of rf_wen=1 on addresses 0..31 with data 0, then cmd_ready=1; a read of (7,31) afterwards -> rsp_data1=0, rsp_data2=0.
REQ-032 Write 0x9 to address 3, then a read of (3,3) in the next cycle -> rsp_valid 2 cycles after read acceptance, with rsp_data1=0x9 and rsp_data2=0x9.
REQ-033 Writes on 4 consecutive cycles (addresses 1..4, data 0xA..0xD) -> cmd_ready held at 1 and rf_wen high for 4 consecutive cycles; a read of (2,4) -> 0xB, 0xD.
REQ-034 Read response with rsp_ready held low for 5 cycles -> rsp_valid and data stable, cmd_ready=0 and rf_stall=1 for all 5 cycles; IDLE in the cycle after rsp_ready=1.
REQ-035 rst asserted in RD_WAIT -> no rsp_valid; all outputs at reset values in the next cycle.
REQ-036 Without RF_CLEAR_EN -> cmd_ready=1 in the first cycle after reset, and no rf_wen pulse is issued without a command.

Source files
------------

// File: rtl/regfile_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : regfile_master                                          |
// | Description : Command front-end for a write-first register file with |
// |               dual read ports; optional post-reset clear sweep is     |
// |               compiled in with macro RF_CLEAR_EN.                     |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module regfile_master #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr1,
  input  logic [ADDR_W-1:0] cmd_addr2,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data1,
  output logic [DATA_W-1:0] rsp_data2,
  output logic [ADDR_W-1:0] rf_rd_addr1,
  output logic [ADDR_W-1:0] rf_rd_addr2,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              rf_wen,
  output logic              rf_stall,
  input  logic [DATA_W-1:0] rf_rd_data1,
  input  logic [DATA_W-1:0] rf_rd_data2
);

  localparam logic [1:0] S_IDLE    = 2'd1;
  localparam logic [1:0] S_RD_WAIT = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;
`ifdef RF_CLEAR_EN
  localparam logic [1:0] S_CLEAR   = 2'd0;
  localparam logic [1:0] S_RESET   = S_CLEAR;
`else
  localparam logic [1:0] S_RESET   = S_IDLE;
`endif

  logic [1:0]        state_q, state_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [DATA_W-1:0] rsp_data1_q, rsp_data1_d;
  logic [DATA_W-1:0] rsp_data2_q, rsp_data2_d;
  logic              cmd_acc;
`ifdef RF_CLEAR_EN
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
`endif

  assign cmd_acc = cmd_valid & cmd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RESET;
      wen_q       <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rsp_data1_q <= '0;
      rsp_data2_q <= '0;
`ifdef RF_CLEAR_EN
      clr_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wen_q       <= wen_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rsp_data1_q <= rsp_data1_d;
      rsp_data2_q <= rsp_data2_d;
`ifdef RF_CLEAR_EN
      clr_cnt_q   <= clr_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    wen_d       = cmd_acc & cmd_we;
    wr_addr_d   = wen_d ? cmd_addr1 : wr_addr_q;
    wr_data_d   = wen_d ? cmd_wdata : wr_data_q;
    // The register file presents read data during RD_WAIT; that is the only capture point.
    rsp_data1_d = (state_q == S_RD_WAIT) ? rf_rd_data1 : rsp_data1_q;
    rsp_data2_d = (state_q == S_RD_WAIT) ? rf_rd_data2 : rsp_data2_q;
`ifdef RF_CLEAR_EN
    clr_cnt_d   = (state_q == S_CLEAR) ? clr_cnt_q + ADDR_W'(1) : clr_cnt_q;
`endif
    case (state_q)
`ifdef RF_CLEAR_EN
      S_CLEAR:   if (clr_cnt_q == {ADDR_W{1'b1}}) state_d = S_IDLE;
`endif
      S_IDLE:    if (cmd_acc && !cmd_we) state_d = S_RD_WAIT;
      S_RD_WAIT: state_d = S_RESP;
      S_RESP:    if (rsp_ready) state_d = S_IDLE;
      default:   state_d = S_RESET;
    endcase
  end

  always_comb begin
    cmd_ready   = (state_q == S_IDLE) && !rst;
    rf_stall    = (state_q == S_RD_WAIT) || (state_q == S_RESP);
    rsp_valid   = (state_q == S_RESP);
    rsp_data1   = rsp_data1_q;
    rsp_data2   = rsp_data2_q;
    rf_rd_addr1 = cmd_addr1;
    rf_rd_addr2 = cmd_addr2;
    rf_wen      = wen_q;
    rf_wr_addr  = wr_addr_q;
    rf_wr_data  = wr_data_q;
`ifdef RF_CLEAR_EN
    if ((state_q == S_CLEAR) && !rst) begin
      rf_wen     = 1'b1;
      rf_wr_addr = clr_cnt_q;
      rf_wr_data = '0;
    end
`endif
  end

endmodule
`default_nettype wire
